bla_pixel_reader: RTL

//  Consumer end of the Bresenham line_buffer interface. When bla_done pulses, snapshots the

---
 rtl/bla_pixel_reader.sv | 99 +++++++++
 1 files changed

// File: rtl/bla_pixel_reader.sv
// Consumer end of the Bresenham line buffer: snapshots the bitmap on bla_done and
// streams one (x,y) write per set bit in raster order, then pulses read_done.
module bla_pixel_reader #(
    parameter int GRID_W  = 64,
    parameter int GRID_H  = 64,
    parameter int COORD_W = 8
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       bla_done,
    input  logic [GRID_W*GRID_H-1:0]   line_buffer,
    output logic                       pixel_valid,
    input  logic                       pixel_ready,
    output logic [COORD_W-1:0]         pixel_x,
    output logic [COORD_W-1:0]         pixel_y,
    output logic                       busy,
    output logic                       read_done,
    output logic [12:0]                pixel_count
);

    localparam int X_W = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int Y_W = (GRID_H > 1) ? $clog2(GRID_H) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] SCAN = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [Y_W-1:0] Y_LAST = Y_W'(GRID_H - 1);

    logic [1:0]               state;
    logic [GRID_W*GRID_H-1:0] snapshot;
    logic [GRID_W-1:0]        row_reg;
    logic [Y_W-1:0]           y_cnt;
    logic [X_W-1:0]           low_idx;

    // Descending walk so the lowest set bit is the last, winning assignment.
    // NOTE: combinational blocks assign a default first so no path leaves a value held (no latch).
    always_comb begin
        low_idx = '0;
        for (int i = GRID_W - 1; i >= 0; i--) begin
            if (row_reg[i]) low_idx = X_W'(i);
        end
    end

    assign pixel_valid = (state == SCAN) && (row_reg != '0);
    assign pixel_x     = pixel_valid ? COORD_W'(low_idx) : '0;
    assign pixel_y     = pixel_valid ? COORD_W'(y_cnt)   : '0;
    assign busy        = (state != IDLE);
    assign read_done   = (state == DONE);

    // NOTE: state uses non-blocking assignments; the snapshot is cleared on reset because
    // it is a flat register, not a RAM, so the reset costs no memory macro.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            snapshot    <= '0;
            row_reg     <= '0;
            y_cnt       <= '0;
            pixel_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bla_done) begin
                        snapshot    <= line_buffer;
                        y_cnt       <= '0;
                        pixel_count <= '0;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    row_reg <= snapshot[int'(y_cnt)*GRID_W +: GRID_W];
                    state   <= SCAN;
                end
                SCAN: begin
                    if (row_reg == '0) begin
                        if (y_cnt == Y_LAST) begin
                            state <= DONE;
                        end else begin
                            y_cnt <= y_cnt + Y_W'(1);
                            state <= LOAD;
                        end
                    end else if (pixel_ready) begin
                        // x & (x-1) drops exactly the lowest set bit, i.e. the pixel just taken.
                        row_reg     <= row_reg & (row_reg - GRID_W'(1));
                        pixel_count <= pixel_count + 13'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
